// File: rtl/mem_pkg.sv
// Shared memory-port definitions: mask size codes, port indices, arbiter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Low two mask bits give the access size; bit 2 requests sign extension.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    // One RAM command as seen on the shared command port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mask;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Read issued last cycle, waiting for its data to come back.
    typedef struct packed {
        logic vld;
        logic port;
    } rd_pend_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between CPU (m0) and debug (m1) ports; m0 wins unless m1 has waited STARVE_LIMIT grants.
// Latency: purely combinational.
// Backpressure: the losing port simply sees no grant and must keep holding its request.
//
// Ports:
//   m0_req, m1_req : port requests
//   starve_cnt     : consecutive m0 grants taken while m1 was waiting
//   gnt_vld        : some port is granted
//   gnt_port       : granted port index (PORT_CPU / PORT_DBG), meaningful with gnt_vld
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic [2:0] starve_cnt,
    output logic       gnt_vld,
    output logic       gnt_port
);

    always_comb begin
        gnt_vld  = m0_req | m1_req;
        gnt_port = PORT_CPU;
        // m1 wins when it is alone, or when contended and it has waited long enough.
        if (m1_req && (!m0_req || (starve_cnt == 3'(STARVE_LIMIT)))) begin
            gnt_port = PORT_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU m0, debug m1) onto a single-command RAM port with anti-starvation for m1.
// Latency: grant and RAM command same cycle; read data and rvalid one cycle after the read grant.
// Backpressure: no queueing; a requester holds req and attributes until its gnt pulses.
//
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   m0_* / m1_*                        : req, we, addr, mask, wdata in; gnt, rvalid out
//   m_rdata                            : read data shared by both ports (ram_rdata passthrough)
//   ram_we/ram_addr/ram_mask/ram_wdata : command to RAM, all zero when idle
//   ram_rdata                          : registered RAM read data
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_mask,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_mask,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,

    output logic [31:0] m_rdata,

    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_mask,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    logic [2:0] starve_cnt;
    rd_pend_t   rd_pend;

    logic       pick_vld;
    logic       pick_port;
    logic       gnt_vld;

    mem_cmd_t   m0_cmd;
    mem_cmd_t   m1_cmd;
    mem_cmd_t   ram_cmd;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .starve_cnt (starve_cnt),
        .gnt_vld    (pick_vld),
        .gnt_port   (pick_port)
    );

    // Reset masks the grant directly so nothing reaches the RAM while it is held.
    assign gnt_vld = pick_vld & ~reset;
    assign m0_gnt  = gnt_vld & (pick_port == PORT_CPU);
    assign m1_gnt  = gnt_vld & (pick_port == PORT_DBG);

    assign m0_cmd = '{we: m0_we, addr: m0_addr, mask: m0_mask, wdata: m0_wdata};
    assign m1_cmd = '{we: m1_we, addr: m1_addr, mask: m1_mask, wdata: m1_wdata};

    always_comb begin
        ram_cmd = '0;
        if (m0_gnt) begin
            ram_cmd = m0_cmd;
        end else if (m1_gnt) begin
            ram_cmd = m1_cmd;
        end
    end

    assign ram_we    = ram_cmd.we;
    assign ram_addr  = ram_cmd.addr;
    assign ram_mask  = ram_cmd.mask;
    assign ram_wdata = ram_cmd.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rd_pend    <= '0;
        end else begin
            // m1 no longer waiting (served or gone): forget the history.
            if (m1_gnt || !m1_req) begin
                starve_cnt <= '0;
            end else if (m0_gnt && (starve_cnt != 3'd7)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            if (gnt_vld && !ram_cmd.we) begin
                rd_pend <= '{vld: 1'b1, port: pick_port};
            end else begin
                rd_pend <= '0;
            end
        end
    end

    // A read granted just before reset is captured in rd_pend on the last
    // pre-reset edge; gating with reset drops its data phase.
    assign m0_rvalid = rd_pend.vld & ~reset & (rd_pend.port == PORT_CPU);
    assign m1_rvalid = rd_pend.vld & ~reset & (rd_pend.port == PORT_DBG);
    assign m_rdata   = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-scenario tasks check grants and RAM command,
// an rvalid scoreboard checks read returns one cycle after each expected read grant.
// The RAM model returns the inverted address of the previous cycle's command.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int LIM = 4;
    localparam logic [2:0] MW = {1'b0, SIZE_WORD};
    localparam logic [2:0] MB = {1'b1, SIZE_BYTE};
    localparam logic [2:0] MH = {1'b1, SIZE_HALF};

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_mask, m1_mask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_mask;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [69:0] obs_v, exp_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_rdata <= ~ram_addr;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_mask   (m0_mask),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_mask   (m1_mask),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m_rdata   (m_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_mask  (ram_mask),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // rvalid scoreboard: exactly the expected port pulses in the due cycle, nothing otherwise.
    always @(negedge clk) begin
        logic        e0, e1;
        logic [31:0] ed;
        e0 = 1'b0;
        e1 = 1'b0;
        ed = '0;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL rvalid_stale cyc=%0d due=%0d port=%0d never returned", cyc, sbq[0].due, sbq[0].port);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e0 = (sbq[0].port == 0);
            e1 = (sbq[0].port == 1);
            ed = sbq[0].data;
            void'(sbq.pop_front());
        end
        total++;
        if (m0_rvalid !== e0 || m1_rvalid !== e1) begin
            bad++;
            $display("FAIL rvalid cyc=%0d got m0=%b m1=%b want m0=%b m1=%b", cyc, m0_rvalid, m1_rvalid, e0, e1);
        end
        if (e0 || e1) begin
            total++;
            if (m_rdata !== ed) begin
                bad++;
                $display("FAIL rdata cyc=%0d got %h want %h", cyc, m_rdata, ed);
            end
        end
    end

    function automatic logic [69:0] sample();
        return {m0_gnt, m1_gnt, ram_we, ram_mask, ram_addr, ram_wdata};
    endfunction

    task automatic set_idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_mask = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_mask = '0; m1_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int port, input logic [31:0] addr);
        exp_t e;
        e.due  = cyc + 1;
        e.port = port;
        e.data = ~addr;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1;
        m0_req = 1; m0_addr = 32'h44; m0_mask = MW;
        m1_req = 1; m1_we = 1; m1_addr = 32'h48; m1_mask = MW; m1_wdata = 32'h1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs_v = sample();
            exp_v = '0;
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset[%0d] got %h want %h", i, obs_v, exp_v);
            end
            next_cycle();
        end
        reset = 0;
        set_idle();
    endtask

    task automatic test_single_read();
        set_idle();
        m0_req = 1; m0_addr = 32'h100; m0_mask = MW;
        @(negedge clk);
        obs_v = sample();
        exp_v = {1'b1, 1'b0, 1'b0, MW, 32'h100, 32'h0};
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL single_m0 got %h want %h", obs_v, exp_v);
        end
        push_rd(0, 32'h100);
        next_cycle();
        set_idle();
        m1_req = 1; m1_addr = 32'h200; m1_mask = MB; m1_wdata = 32'h77;
        @(negedge clk);
        obs_v = sample();
        exp_v = {1'b0, 1'b1, 1'b0, MB, 32'h200, 32'h77};
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL single_m1 got %h want %h", obs_v, exp_v);
        end
        push_rd(1, 32'h200);
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_starve();
        set_idle();
        m0_req = 1; m0_addr = 32'h10; m0_mask = MW;
        m1_req = 1; m1_addr = 32'h14; m1_mask = MH;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            obs_v = sample();
            if (i % 5 == 4) exp_v = {1'b0, 1'b1, 1'b0, MH, 32'h14, 32'h0};
            else            exp_v = {1'b1, 1'b0, 1'b0, MW, 32'h10, 32'h0};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL starve[%0d] got %h want %h", i, obs_v, exp_v);
            end
            if (i % 5 == 4) push_rd(1, 32'h14);
            else            push_rd(0, 32'h10);
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_write_then_read();
        set_idle();
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_mask = MW; m0_wdata = 32'hDEADBEEF;
        m1_req = 1; m1_addr = 32'h40; m1_mask = MW; m1_wdata = 32'h0BADF00D;
        @(negedge clk);
        obs_v = sample();
        exp_v = {1'b1, 1'b0, 1'b1, MW, 32'h20, 32'hDEADBEEF};
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL wr_cycle1 got %h want %h", obs_v, exp_v);
        end
        next_cycle();
        m0_req = 0; m0_we = 0;
        @(negedge clk);
        obs_v = sample();
        exp_v = {1'b0, 1'b1, 1'b0, MW, 32'h40, 32'h0BADF00D};
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL wr_cycle2 got %h want %h", obs_v, exp_v);
        end
        push_rd(1, 32'h40);
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 8; i++) begin
            set_idle();
            if (i % 2 == 0) begin m0_req = 1; m0_addr = 32'h0; m0_mask = MW; end
            else            begin m1_req = 1; m1_addr = 32'h4; m1_mask = MW; end
            @(negedge clk);
            obs_v = sample();
            if (i % 2 == 0) exp_v = {1'b1, 1'b0, 1'b0, MW, 32'h0, 32'h0};
            else            exp_v = {1'b0, 1'b1, 1'b0, MW, 32'h4, 32'h0};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL alternate[%0d] got %h want %h", i, obs_v, exp_v);
            end
            push_rd(i % 2, (i % 2 == 0) ? 32'h0 : 32'h4);
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_reset_discard();
        set_idle();
        m1_req = 1; m1_addr = 32'h80; m1_mask = MW;
        @(negedge clk);
        obs_v = sample();
        exp_v = {1'b0, 1'b1, 1'b0, MW, 32'h80, 32'h0};
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL discard_gnt got %h want %h", obs_v, exp_v);
        end
        next_cycle();
        reset = 1;
        m0_req = 1; m0_addr = 32'h84; m0_mask = MW;
        @(negedge clk);
        obs_v = sample();
        exp_v = '0;
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL discard_rst got %h want %h", obs_v, exp_v);
        end
        next_cycle();
        reset = 0;
        // Build up the starvation count, then reset; afterwards m0 must again get four turns.
        m0_req = 1; m0_addr = 32'h90; m0_mask = MW;
        m1_req = 1; m1_addr = 32'h94; m1_mask = MW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs_v = sample();
            exp_v = {1'b1, 1'b0, 1'b0, MW, 32'h90, 32'h0};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL prerst[%0d] got %h want %h", i, obs_v, exp_v);
            end
            if (i < 2) push_rd(0, 32'h90);
            next_cycle();
        end
        reset = 1;
        @(negedge clk);
        obs_v = sample();
        exp_v = '0;
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL midrst got %h want %h", obs_v, exp_v);
        end
        next_cycle();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs_v = sample();
            if (i == 4) exp_v = {1'b0, 1'b1, 1'b0, MW, 32'h94, 32'h0};
            else        exp_v = {1'b1, 1'b0, 1'b0, MW, 32'h90, 32'h0};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL postrst[%0d] got %h want %h", i, obs_v, exp_v);
            end
            if (i == 4) push_rd(1, 32'h94);
            else        push_rd(0, 32'h90);
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_idle();
        set_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs_v = sample();
            exp_v = '0;
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL idle[%0d] got %h want %h", i, obs_v, exp_v);
            end
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        set_idle();
        test_reset();
        test_single_read();
        test_starve();
        test_write_then_read();
        test_alternate();
        test_reset_discard();
        test_idle();
        next_cycle();
        next_cycle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending reads want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
